// File: rtl/mmio_uart_rx_if.sv
// CPU data-memory bus as seen by a memory-mapped peripheral in the MEM stage.
// The master drives the address and strobes; the slave answers with hit and read data.
interface mmio_uart_rx_if;
  logic [31:0] addr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (
    output addr, MemRead, MemWrite, WriteData,
    input  ReadData, hit
  );

  modport slave (
    input  addr, MemRead, MemWrite, WriteData,
    output ReadData, hit
  );
endinterface

// File: rtl/mmio_uart_rx.sv
// Memory-mapped 8N1 UART receiver: 16x oversampling, small receive FIFO,
// RXDATA (pop on load) and STATUS (sticky error flags, write-1-to-clear) registers.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | counting to mid start bit; a high sample there is a glitch
// DATA   | sampling 8 data bits mid-bit, LSB first
// STOP   | sampling mid stop bit; high pushes the byte, low is a framing error
// BREAK  | framing error seen, waiting for the line to return high
module mmio_uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_rx_if.slave  bus,
  input  logic           rx,
  output logic           rx_irq
);

  localparam int unsigned DIV         = CLK_FREQ / (16 * BAUD);
  localparam int unsigned DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // synchronizer and baud divider
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rx_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  // receive FSM and datapath
  state_t     state_q, state_d;
  logic [3:0] sc_q, sc_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] shreg_q, shreg_d;
  logic       byte_done;
  logic       push;
  logic       frame_set;

  // FIFO and flags
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_irq_q, rx_irq_d;

  // bus decode
  logic        sel_data;
  logic        sel_status;
  logic        empty;
  logic        full;
  logic        pop_req;
  logic        pop_ok;
  logic        push_ok;
  logic        overrun_set;
  logic        status_clr;
  logic [7:0]  head;
  logic [31:0] status_word;
  logic        unused_wdata;

  assign unused_wdata = ^{bus.WriteData[31:4], bus.WriteData[1:0]};

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    rx_s    = sync2_q;
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + DIV_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      bc_q    <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      shreg_q <= shreg_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bc_d    = bc_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          sc_d    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (sc_q == 4'd7) begin
            sc_d = '0;
            if (!rx_s) begin
              state_d = S_DATA;
              bc_d    = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            bc_d    = bc_q + 3'd1;
            if (bc_q == 3'd7) begin
              state_d = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            state_d = rx_s ? S_IDLE : S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    byte_done = (state_q == S_STOP) && tick && (sc_q == 4'd15);
    push      = byte_done && rx_s;
    frame_set = byte_done && !rx_s;
  end

  always_comb begin
    sel_data    = (bus.addr == BASE_ADDR);
    sel_status  = (bus.addr == STATUS_ADDR);
    empty       = (count_q == '0);
    full        = (count_q == DEPTH_C);
    head        = mem_q[rd_ptr_q];
    pop_req     = bus.MemRead && sel_data;
    status_clr  = bus.MemWrite && sel_status;
    status_word = {19'd0, 5'(count_q), 4'd0, frame_err_q, overrun_q, full, !empty};

    bus.hit      = sel_data || sel_status;
    bus.ReadData = '0;
    if (sel_data) begin
      bus.ReadData = empty ? 32'd0 : {24'd0, head};
    end else if (sel_status) begin
      bus.ReadData = status_word;
    end
  end

  // a full FIFO still accepts a push when a pop frees the head slot on the same edge
  always_comb begin
    pop_ok      = pop_req && !empty;
    push_ok     = push && (!full || pop_ok);
    overrun_set = push && !push_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shreg_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overrun_d   = overrun_set || (overrun_q && !(status_clr && bus.WriteData[2]));
    frame_err_d = frame_set || (frame_err_q && !(status_clr && bus.WriteData[3]));
    rx_irq_d    = !empty;
    rx_irq      = rx_irq_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      div_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_irq_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_q       <= div_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_irq_q    <= rx_irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_rx.sv
// Bench for mmio_uart_rx at 16 clocks per bit, FIFO depth 4.
// Expected bytes and flags come from a queue-based model of the receiver.
module tb_mmio_uart_rx;

  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] STAT = 32'h4000_001C;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic rx_irq;

  mmio_uart_rx_if bus ();

  mmio_uart_rx #(
    .CLK_FREQ  (16_000_000),
    .BAUD      (1_000_000),
    .FIFO_DEPTH(4),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .rx    (rx),
    .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_q[$];
  bit m_ovr;
  bit m_ferr;

  function automatic logic [31:0] exp_status();
    int cnt;
    cnt = model_q.size();
    exp_status = (32'(cnt) << 8) | (32'(m_ferr) << 3) | (32'(m_ovr) << 2)
               | (32'(cnt == 4) << 1) | 32'(cnt != 0);
  endfunction

  function automatic void model_rx(input logic [7:0] b);
    if (model_q.size() < 4) model_q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] model_pop();
    if (model_q.size() == 0) return 32'd0;
    return {24'd0, model_q.pop_front()};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame (start, 8 data LSB first, stop) for ncyc clocks; optionally loads RXDATA in cycle pop_cycle.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int pop_cycle,
                            input int ncyc, output logic [31:0] popped);
    popped = 32'd0;
    @(posedge clk);
    #1;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 16) rx = 1'b0;
      else if (c < 144) rx = data[(c - 16) / 16];
      else rx = stop_bit;
      if (c == pop_cycle) begin
        bus.addr = BASE;
        bus.MemRead = 1'b1;
        #1 popped = bus.ReadData;
        @(posedge clk);
        #1;
        bus.MemRead = 1'b0;
        bus.addr = 32'd0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] data);
    logic [31:0] dummy;
    send_frame(data, 1'b1, -1, 160, dummy);
    rx = 1'b1;
  endtask

  task automatic read_rxdata(output logic [31:0] v);
    bus.addr = BASE;
    bus.MemRead = 1'b1;
    #1 v = bus.ReadData;
    @(posedge clk);
    #1;
    bus.MemRead = 1'b0;
    bus.addr = 32'd0;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.addr = STAT;
    #1 v = bus.ReadData;
    bus.addr = 32'd0;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] wd);
    bus.addr = a;
    bus.WriteData = wd;
    bus.MemWrite = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    bus.addr = 32'd0;
    bus.WriteData = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    read_status(v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'd0); end
    checks++;
    if (rx_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", rx_irq); end
    bus.addr = BASE;
    #1;
    checks++;
    if (bus.hit !== 1'b1 || bus.ReadData !== 32'd0) begin
      failures++; $display("FAIL reset_rxdata hit=%b data=%h exp hit=1 data=0", bus.hit, bus.ReadData);
    end
    bus.addr = 32'd0;
  endtask

  task automatic test_single_byte();
    logic [31:0] v;
    send_byte(8'hA5);
    model_rx(8'hA5);
    idle(2);
    read_status(v);
    checks++;
    if (v !== 32'h0000_0101) begin failures++; $display("FAIL single_status got=%h exp=%h", v, 32'h101); end
    checks++;
    if (rx_irq !== 1'b1) begin failures++; $display("FAIL single_irq_high got=%b exp=1", rx_irq); end
    read_rxdata(v);
    checks++;
    if (v !== model_pop()) begin failures++; $display("FAIL single_rxdata got=%h exp=%h", v, 32'hA5); end
    read_status(v);
    checks++;
    if (v !== exp_status()) begin failures++; $display("FAIL single_status_after got=%h exp=%h", v, exp_status()); end
    idle(1);
    checks++;
    if (rx_irq !== 1'b0) begin failures++; $display("FAIL single_irq_low got=%b exp=0", rx_irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(24);
    read_status(v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL glitch_status got=%h exp=0", v); end
    send_byte(8'h3A);
    model_rx(8'h3A);
    idle(2);
    read_rxdata(v);
    checks++;
    if (v !== model_pop()) begin failures++; $display("FAIL glitch_next_byte got=%h exp=3a", v); end
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    logic [31:0] e;
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i));
      model_rx(8'(i));
    end
    idle(2);
    read_status(v);
    checks++;
    if (v !== 32'h0000_0407 || v !== exp_status()) begin
      failures++; $display("FAIL overrun_status got=%h exp=%h", v, 32'h407);
    end
    for (int i = 0; i < 5; i++) begin
      e = model_pop();
      read_rxdata(v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL overrun_read%0d got=%h exp=%h", i, v, e); end
    end
    write_reg(STAT, 32'h4);
    m_ovr = 1'b0;
    read_status(v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL overrun_clear got=%h exp=0", v); end
  endtask

  task automatic test_frame_err();
    logic [31:0] v;
    logic [31:0] dummy;
    send_frame(8'h3C, 1'b0, -1, 160, dummy);
    idle(40);
    rx = 1'b1;
    idle(4);
    m_ferr = 1'b1;
    read_status(v);
    checks++;
    if (v !== exp_status() || v !== 32'h8) begin
      failures++; $display("FAIL frame_err_status got=%h exp=%h", v, 32'h8);
    end
    send_byte(8'h55);
    model_rx(8'h55);
    idle(2);
    read_rxdata(v);
    checks++;
    if (v !== model_pop()) begin failures++; $display("FAIL frame_err_recover got=%h exp=55", v); end
    write_reg(STAT, 32'h8);
    m_ferr = 1'b0;
    read_status(v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL frame_err_clear got=%h exp=0", v); end
  endtask

  task automatic test_address_decode();
    logic [31:0] v;
    logic [31:0] bad [4];
    send_byte(8'h11);
    model_rx(8'h11);
    idle(2);
    bad[0] = BASE + 32'd1;
    bad[1] = BASE + 32'd2;
    bad[2] = BASE + 32'd8;
    bad[3] = BASE - 32'd4;
    for (int i = 0; i < 4; i++) begin
      bus.addr = bad[i];
      bus.MemRead = 1'b1;
      #1;
      checks++;
      if (bus.hit !== 1'b0 || bus.ReadData !== 32'd0) begin
        failures++; $display("FAIL decode_bad%0d hit=%b data=%h exp hit=0 data=0", i, bus.hit, bus.ReadData);
      end
      @(posedge clk);
      #1;
      bus.MemRead = 1'b0;
    end
    write_reg(BASE, 32'hFFFF_FFFF);
    bus.addr = STAT;
    #1;
    checks++;
    if (bus.hit !== 1'b1) begin failures++; $display("FAIL decode_status_hit got=%b exp=1", bus.hit); end
    read_status(v);
    checks++;
    if (v !== exp_status()) begin failures++; $display("FAIL decode_no_side_effect got=%h exp=%h", v, exp_status()); end
    read_rxdata(v);
    checks++;
    if (v !== model_pop()) begin failures++; $display("FAIL decode_byte got=%h exp=11", v); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    logic [31:0] dummy;
    send_byte(8'h99);
    model_rx(8'h99);
    send_frame(8'h81, 1'b1, -1, 88, dummy);
    reset = 1'b1;
    rx = 1'b1;
    idle(3);
    reset = 1'b0;
    model_q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    idle(1);
    read_status(v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL midreset_status got=%h exp=0", v); end
    checks++;
    if (rx_irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b exp=0", rx_irq); end
    send_byte(8'h7E);
    model_rx(8'h7E);
    idle(20);
    read_status(v);
    checks++;
    if (v !== 32'h101) begin failures++; $display("FAIL midreset_count got=%h exp=%h", v, 32'h101); end
    read_rxdata(v);
    checks++;
    if (v !== model_pop()) begin failures++; $display("FAIL midreset_byte got=%h exp=7e", v); end
  endtask

  task automatic test_pop_on_push();
    logic [31:0] v;
    logic [31:0] e;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_byte(b);
      model_rx(b);
    end
    b = 8'($urandom);
    send_frame(b, 1'b1, 154, 160, v);
    rx = 1'b1;
    e = model_pop();
    model_rx(b);
    checks++;
    if (v !== e) begin failures++; $display("FAIL poppush_head got=%h exp=%h", v, e); end
    idle(2);
    read_status(v);
    checks++;
    if (v !== exp_status() || v !== 32'h403) begin
      failures++; $display("FAIL poppush_status got=%h exp=%h", v, 32'h403);
    end
    for (int i = 0; i < 4; i++) begin
      e = model_pop();
      read_rxdata(v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL poppush_drain%0d got=%h exp=%h", i, v, e); end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] e;
    logic [7:0] b;
    int n;
    for (int burst = 0; burst < 8; burst++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        send_byte(b);
        model_rx(b);
        idle($urandom_range(0, 20));
      end
      idle(2);
      read_status(v);
      checks++;
      if (v !== exp_status()) begin failures++; $display("FAIL rand_status b%0d got=%h exp=%h", burst, v, exp_status()); end
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        e = model_pop();
        read_rxdata(v);
        checks++;
        if (v !== e) begin failures++; $display("FAIL rand_read b%0d i%0d got=%h exp=%h", burst, i, v, e); end
      end
      if ($urandom_range(0, 1) == 1) begin
        write_reg(STAT, 32'h4);
        m_ovr = 1'b0;
      end
    end
    while (model_q.size() != 0) begin
      e = model_pop();
      read_rxdata(v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL rand_drain got=%h exp=%h", v, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    bus.addr = 32'd0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.WriteData = 32'd0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);
    test_reset();
    test_single_byte();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_address_decode();
    test_reset_midframe();
    test_pop_on_push();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
